screen_fade_fx: RTL and testbench
=================================

Name: screen_fade_fx

Overview:
- Post-mux video stage. Consumes the 8-bit RGB332 pixel stream from the objects mux and drives the VGA controller's pixel input.
- Fades the whole screen to black or back to full brightness over several frames, for game start, win and lose transitions.
- Brightness changes only on frame boundaries, so no tearing.
- Adds one registered pipeline stage.

Parameters:
- FADE_SHIFT, 3: number of brightness steps is 1<<FADE_SHIFT (8 by default). Full brightness level = 1<<FADE_SHIFT.
- FRAMES_PER_STEP, 4: startOfFrame pulses per brightness step. Legal range 1..255.
- FLASH_FRAMES, 6: frames of white flash. Used only with FADE_FLASH_EN.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at the start of vertical blanking
- fadeOutReq  in  1  level/pulse request to fade to black
- fadeInReq  in  1  level/pulse request to fade to full brightness
- flashReq  in  1  white-flash trigger; ignored unless FADE_FLASH_EN
- RGBIn  in  8  RGB332 pixel from the objects mux: R[7:5], G[4:2], B[1:0]
- RGBOut  out  8  scaled RGB332 pixel to the VGA controller
- level  out  FADE_SHIFT+1  current brightness, 0..(1<<FADE_SHIFT)
- busy  out  1  high while in FADING_OUT or FADING_IN
- fadeDone  out  1  one-cycle pulse when DARK or BRIGHT is reached

Behaviour:
- Reset values: state=BRIGHT, level=1<<FADE_SHIFT, frameCnt=0, RGBOut=8'h00, busy=0, fadeDone=0. A reset mid-fade abandons the fade immediately.
- Datapath:
  - RGBOut <= {(R*level)>>FADE_SHIFT, (G*level)>>FADE_SHIFT, (B*level)>>FADE_SHIFT}.
  - Latency is exactly 1 clk from RGBIn.
  - Intermediate products are unsigned and full width. Results truncate to 3/3/2 bits and never overflow, since level <= 1<<FADE_SHIFT.
- States:
  - BRIGHT: level=max.
  - FADING_OUT.
  - DARK: level=0.
  - FADING_IN.
- Transitions, evaluated every clk:
  - BRIGHT or FADING_IN + fadeOutReq -> FADING_OUT, frameCnt=0. Fade starts from the current level, with no jump.
  - DARK or FADING_OUT + fadeInReq -> FADING_IN, frameCnt=0.
  - fadeOutReq and fadeInReq together: fadeOutReq wins.
  - A request matching the current direction or end state is ignored. Counters are not restarted.
- Stepping, in FADING_OUT / FADING_IN, only on startOfFrame:
  - If frameCnt==FRAMES_PER_STEP-1: level -/+ 1 and frameCnt=0.
  - Otherwise frameCnt++.
- Completion:
  - When level reaches 0 (out) or max (in), the state moves to DARK or BRIGHT on the same edge.
  - fadeDone is high for exactly the following cycle.
- A request arriving on the same cycle as startOfFrame: the direction change takes effect and no step occurs that cycle.
- busy = state is FADING_OUT or FADING_IN, registered together with state.
- Full fade time = (1<<FADE_SHIFT)*FRAMES_PER_STEP frames (32 by default).

Optional Feature:
- Macro: FADE_FLASH_EN.
- Defined:
  - flashReq loads flashCnt=FLASH_FRAMES.
  - While flashCnt!=0, RGBOut <= 8'hFF regardless of level. flashCnt decrements on each startOfFrame.
  - The fade FSM keeps running underneath.
  - A retrigger during a flash reloads flashCnt.
  - Reset clears flashCnt.
- Undefined: flashReq is ignored, no flash logic is built, and RGBOut is always the scaled pixel.

Test Plan:
- Reset, then RGBIn=8'hFF -> RGBOut=8'hFF one clk later; level=8; busy=0.
- fadeOutReq pulse, RGBIn=8'hFF:
  - After 4 startOfFrame pulses -> level=7, RGBOut=8'hDA.
  - After 16 pulses -> level=4, RGBOut=8'h6D.
  - After 32 pulses -> level=0, RGBOut=8'h00; fadeDone high for 1 clk; busy=0.
- From DARK, fadeInReq -> after 32 startOfFrame pulses level=8 and fadeDone pulses. Then fadeInReq again -> ignored, busy stays 0.
- Mid-fade-out at level=5, fadeInReq -> level rises to 6 after 4 startOfFrame pulses. fadeInReq+fadeOutReq together -> FADING_OUT.
- Assert resetN=0 at level=3 during a fade -> RGBOut=8'h00 immediately, level=8 and state=BRIGHT after release.
- With FADE_FLASH_EN, flashReq at level=2 -> RGBOut=8'hFF for 6 frames, then the scaled pixel at the current level. Without the macro, RGBOut is unaffected.

Source files
------------

// File: rtl/screen_fade_fx.sv
// rtl/screen_fade_fx.sv - frame-synchronous fade-to-black / fade-in stage for an RGB332 pixel stream
// Optional white flash overlay built only when FADE_FLASH_EN is defined.
module screen_fade_fx #(
    parameter int FADE_SHIFT      = 3,
    parameter int FRAMES_PER_STEP = 4,
    parameter int FLASH_FRAMES    = 6
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  fadeOutReq,
    input  logic                  fadeInReq,
    input  logic                  flashReq,
    input  logic [7:0]            RGBIn,
    output logic [7:0]            RGBOut,
    output logic [FADE_SHIFT:0]   level,
    output logic                  busy,
    output logic                  fadeDone
);

    localparam int               LW        = FADE_SHIFT + 1;
    localparam logic [LW-1:0]    LEVEL_MAX = LW'(1 << FADE_SHIFT);
    localparam logic [7:0]       FPS_LAST  = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        BRIGHT     = 2'd0,
        FADING_OUT = 2'd1,
        DARK       = 2'd2,
        FADING_IN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            busy_q, busy_d;
    logic            fade_done_q, fade_done_d;
    logic [7:0]      rgb_out_q, rgb_out_d;

    logic            fading;
    logic [2+LW:0]   r_prod;
    logic [2+LW:0]   g_prod;
    logic [1+LW:0]   b_prod;
    logic [7:0]      scaled;

    assign fading = (state_q == FADING_OUT) || (state_q == FADING_IN);

    // Products are full width; level never exceeds 1<<FADE_SHIFT so the shifted result fits.
    assign r_prod = (3 + LW)'(RGBIn[7:5]) * (3 + LW)'(level_q);
    assign g_prod = (3 + LW)'(RGBIn[4:2]) * (3 + LW)'(level_q);
    assign b_prod = (2 + LW)'(RGBIn[1:0]) * (2 + LW)'(level_q);
    assign scaled = {3'(r_prod >> FADE_SHIFT), 3'(g_prod >> FADE_SHIFT), 2'(b_prod >> FADE_SHIFT)};

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        fade_done_d = 1'b0;
        // Direction changes win over a coincident frame step; fade-out wins over fade-in.
        if (fadeOutReq && (state_q == BRIGHT || state_q == FADING_IN)) begin
            state_d     = FADING_OUT;
            frame_cnt_d = 8'd0;
        end else if (!fadeOutReq && fadeInReq && (state_q == DARK || state_q == FADING_OUT)) begin
            state_d     = FADING_IN;
            frame_cnt_d = 8'd0;
        end else if (startOfFrame && fading) begin
            if (frame_cnt_q == FPS_LAST) begin
                frame_cnt_d = 8'd0;
                if (state_q == FADING_OUT) begin
                    if (level_q <= LW'(1)) begin
                        level_d     = '0;
                        state_d     = DARK;
                        fade_done_d = 1'b1;
                    end else begin
                        level_d = level_q - LW'(1);
                    end
                end else begin
                    if (level_q >= LEVEL_MAX - LW'(1)) begin
                        level_d     = LEVEL_MAX;
                        state_d     = BRIGHT;
                        fade_done_d = 1'b1;
                    end else begin
                        level_d = level_q + LW'(1);
                    end
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
        busy_d = (state_d == FADING_OUT) || (state_d == FADING_IN);
    end

`ifdef FADE_FLASH_EN
    logic [7:0] flash_cnt_q, flash_cnt_d;

    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flashReq) begin
            flash_cnt_d = 8'(FLASH_FRAMES);
        end else if (startOfFrame && flash_cnt_q != 8'd0) begin
            flash_cnt_d = flash_cnt_q - 8'd1;
        end
        rgb_out_d = (flash_cnt_q != 8'd0) ? 8'hFF : scaled;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flash_cnt_q <= 8'd0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
        end
    end
`else
    logic flash_unused;
    assign flash_unused = flashReq ^ (FLASH_FRAMES == 0);

    always_comb begin
        rgb_out_d = scaled;
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= BRIGHT;
            level_q     <= LEVEL_MAX;
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b0;
            fade_done_q <= 1'b0;
            rgb_out_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            fade_done_q <= fade_done_d;
            rgb_out_q   <= rgb_out_d;
        end
    end

    assign RGBOut   = rgb_out_q;
    assign level    = level_q;
    assign busy     = busy_q;
    assign fadeDone = fade_done_q;

endmodule

// File: tb/tb_screen_fade_fx.sv
// tb/tb_screen_fade_fx.sv - directed scoreboard bench for screen_fade_fx
module tb_screen_fade_fx;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       fadeOutReq = 1'b0;
    logic       fadeInReq = 1'b0;
    logic       flashReq = 1'b0;
    logic [7:0] RGBIn = 8'h00;
    logic [7:0] RGBOut;
    logic [3:0] level;
    logic       busy;
    logic       fadeDone;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    screen_fade_fx dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .fadeOutReq(fadeOutReq), .fadeInReq(fadeInReq), .flashReq(flashReq),
        .RGBIn(RGBIn), .RGBOut(RGBOut), .level(level), .busy(busy), .fadeDone(fadeDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] scale(input logic [7:0] pix, input int lvl);
        int r, g, b;
        r = (int'(pix[7:5]) * lvl) / 8;
        g = (int'(pix[4:2]) * lvl) / 8;
        b = (int'(pix[1:0]) * lvl) / 8;
        return {r[2:0], g[2:0], b[1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic drive_pixel(input string tag, input logic [7:0] pix, input logic [7:0] expected);
        logic [7:0] e;
        RGBIn = pix;
        exp_q.push_back(expected);
        tick();
        e = exp_q.pop_front();
        check(tag, RGBOut, e);
    endtask

    task automatic pulse_req(input logic o, input logic i);
        fadeOutReq = o;
        fadeInReq  = i;
        tick();
        fadeOutReq = 1'b0;
        fadeInReq  = 1'b0;
    endtask

    initial begin
        RGBIn = 8'hFF;
        tick();
        tick();
        check("rst_rgb", RGBOut, 8'h00);
        check("rst_level", level, 4'd8);
        check("rst_busy", busy, 1'b0);
        check("rst_done", fadeDone, 1'b0);
        resetN = 1'b1;
        tick();

        drive_pixel("bright_ff", 8'hFF, 8'hFF);
        drive_pixel("bright_mix", 8'hA5, scale(8'hA5, 8));
        check("bright_level", level, 4'd8);
        check("bright_busy", busy, 1'b0);

        pulse_req(1'b1, 1'b0);
        check("out_busy", busy, 1'b1);
        check("out_level0", level, 4'd8);
        sof(3);
        check("out_3sof", level, 4'd8);
        sof(1);
        check("out_4sof", level, 4'd7);
        drive_pixel("out_l7", 8'hFF, 8'hDA);
        sof(12);
        check("out_16sof", level, 4'd4);
        drive_pixel("out_l4", 8'hFF, 8'h6D);
        drive_pixel("out_l4_mix", 8'h5B, scale(8'h5B, 4));
        sof(15);
        check("out_31sof", level, 4'd1);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("dark_level", level, 4'd0);
        check("dark_done", fadeDone, 1'b1);
        check("dark_busy", busy, 1'b0);
        tick();
        check("dark_done_clr", fadeDone, 1'b0);
        drive_pixel("dark_rgb", 8'hFF, 8'h00);

        pulse_req(1'b0, 1'b1);
        check("in_busy", busy, 1'b1);
        sof(31);
        check("in_31sof", level, 4'd7);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("bright_again", level, 4'd8);
        check("in_done", fadeDone, 1'b1);
        check("in_busy_clr", busy, 1'b0);
        tick();
        check("in_done_clr", fadeDone, 1'b0);
        pulse_req(1'b0, 1'b1);
        check("in_ignored_busy", busy, 1'b0);
        check("in_ignored_done", fadeDone, 1'b0);
        sof(4);
        check("in_ignored_level", level, 4'd8);

        pulse_req(1'b1, 1'b0);
        sof(12);
        check("mid_l5", level, 4'd5);
        pulse_req(1'b0, 1'b1);
        sof(3);
        check("rev_3sof", level, 4'd5);
        sof(1);
        check("rev_l6", level, 4'd6);
        check("rev_busy", busy, 1'b1);
        sof(2);
        pulse_req(1'b1, 1'b1);
        sof(3);
        check("both_no_step", level, 4'd6);
        sof(1);
        check("both_out_l5", level, 4'd5);
        sof(3);
        startOfFrame = 1'b1;
        fadeInReq    = 1'b1;
        tick();
        startOfFrame = 1'b0;
        fadeInReq    = 1'b0;
        check("sof_req_no_step", level, 4'd5);
        sof(3);
        check("sof_req_cnt_clr", level, 4'd5);
        sof(1);
        check("sof_req_in_l6", level, 4'd6);

        pulse_req(1'b1, 1'b0);
        sof(12);
        check("pre_rst_l3", level, 4'd3);
        drive_pixel("l3_rgb", 8'hFF, 8'h49);
        resetN = 1'b0;
        #1;
        check("async_rgb", RGBOut, 8'h00);
        check("async_level", level, 4'd8);
        check("async_busy", busy, 1'b0);
        tick();
        resetN = 1'b1;
        tick();
        check("post_rst_level", level, 4'd8);
        sof(4);
        check("post_rst_idle", level, 4'd8);
        drive_pixel("post_rst_rgb", 8'hFF, 8'hFF);

        pulse_req(1'b1, 1'b0);
        sof(24);
        check("flash_l2", level, 4'd2);
        flashReq = 1'b1;
        tick();
        flashReq = 1'b0;
`ifdef FADE_FLASH_EN
        for (int i = 0; i < 6; i++) begin
            drive_pixel("flash_white", 8'h24, 8'hFF);
            sof(1);
        end
        check("flash_end_level", level, 4'd1);
        drive_pixel("flash_done_rgb", 8'hFF, scale(8'hFF, 1));
`else
        drive_pixel("noflash_rgb", 8'hFF, 8'h24);
        sof(1);
        drive_pixel("noflash_rgb2", 8'hB6, scale(8'hB6, 2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
